status_flag_register: RTL and testbench

//  Holds the processor's N/Z/C/V status flags, applying per-flag write enables from the flag write-enable decode.

---
 rtl/status_flag_register.sv | 131 +++++++++++++
 tb/tb_status_flag_register.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/status_flag_register.sv
// N/Z/C/V status flag register with per-flag write enables, a one-deep shadow copy
// for exception save/restore, and a registered condition-code evaluator.
module status_flag_register #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter bit         SHADOW_EN   = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_alu_n,
    input  logic       i_alu_z,
    input  logic       i_alu_c,
    input  logic       i_alu_v,
    input  logic       i_n_write,
    input  logic       i_z_write,
    input  logic       i_c_write,
    input  logic       i_v_write,
    input  logic       i_save,
    input  logic       i_restore,
    input  logic       i_cond_req,
    input  logic [3:0] i_cond_code,
    output logic [3:0] o_flags,
    output logic [3:0] o_shadow_flags,
    output logic       o_cond_valid,
    output logic       o_cond_true
);

    logic [3:0] r_flags;
    logic [3:0] r_shadow;
    logic       r_cond_valid;
    logic       r_cond_true;

    logic [3:0] w_alu;
    logic [3:0] w_write_en;
    logic [3:0] w_next_flags;
    logic       w_save;
    logic       w_restore;
    logic       w_cond;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign w_alu      = {i_alu_n, i_alu_z, i_alu_c, i_alu_v};
    assign w_write_en = {i_n_write, i_z_write, i_c_write, i_v_write};
    assign w_save     = SHADOW_EN && i_save;
    assign w_restore  = SHADOW_EN && i_restore;

    // Restore takes priority over any ALU flag writes in the same cycle.
    always_comb begin
        w_next_flags = r_flags;
        for (int i = 0; i < 4; i++) begin
            if (w_write_en[i]) begin
                w_next_flags[i] = w_alu[i];
            end
        end
        if (w_restore) begin
            w_next_flags = r_shadow;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flags <= RESET_FLAGS;
        end else begin
            r_flags <= w_next_flags;
        end
    end

    generate
        if (SHADOW_EN) begin : g_shadow
            // Save captures the pre-edge flags, so save+restore together swaps them.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_shadow <= RESET_FLAGS;
                end else if (w_save) begin
                    r_shadow <= r_flags;
                end
            end
        end else begin : g_no_shadow
            always_ff @(posedge i_clk) begin
                r_shadow <= 4'b0000;
            end
        end
    endgenerate

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluated against held flags only; same-cycle writes are deliberately not bypassed.
    always_comb begin
        w_cond = 1'b0;
        case (i_cond_code)
            4'h0: w_cond = w_z;
            4'h1: w_cond = !w_z;
            4'h2: w_cond = w_c;
            4'h3: w_cond = !w_c;
            4'h4: w_cond = w_n;
            4'h5: w_cond = !w_n;
            4'h6: w_cond = w_v;
            4'h7: w_cond = !w_v;
            4'h8: w_cond = w_c && !w_z;
            4'h9: w_cond = !w_c || w_z;
            4'hA: w_cond = (w_n == w_v);
            4'hB: w_cond = (w_n != w_v);
            4'hC: w_cond = !w_z && (w_n == w_v);
            4'hD: w_cond = w_z || (w_n != w_v);
            4'hE: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cond_valid <= 1'b0;
            r_cond_true  <= 1'b0;
        end else begin
            r_cond_valid <= i_cond_req;
            if (i_cond_req) begin
                r_cond_true <= w_cond;
            end
        end
    end

    assign o_flags        = r_flags;
    assign o_shadow_flags = r_shadow;
    assign o_cond_valid   = r_cond_valid;
    assign o_cond_true    = r_cond_true;

endmodule

// File: tb/tb_status_flag_register.sv
// Self-checking bench for status_flag_register: directed vectors driven one cycle at a time,
// a flag/shadow/condition model updated per edge, and literal checks at key points.
module tb_status_flag_register;

    logic       clk;
    logic       rst;
    logic       aluN, aluZ, aluC, aluV;
    logic       nWrite, zWrite, cWrite, vWrite;
    logic       save, restore;
    logic       condReq;
    logic [3:0] condCode;
    logic [3:0] flags;
    logic [3:0] shadowFlags;
    logic       condValid;
    logic       condTrue;

    int errorCount = 0;
    int checkCount = 0;

    // Model state
    logic [3:0] mFlags  = 4'b0000;
    logic [3:0] mShadow = 4'b0000;
    logic       mValid  = 1'b0;
    logic       mTrue   = 1'b0;

    status_flag_register #(
        .RESET_FLAGS(4'b0000),
        .SHADOW_EN  (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alu_n       (aluN),
        .i_alu_z       (aluZ),
        .i_alu_c       (aluC),
        .i_alu_v       (aluV),
        .i_n_write     (nWrite),
        .i_z_write     (zWrite),
        .i_c_write     (cWrite),
        .i_v_write     (vWrite),
        .i_save        (save),
        .i_restore     (restore),
        .i_cond_req    (condReq),
        .i_cond_code   (condCode),
        .o_flags       (flags),
        .o_shadow_flags(shadowFlags),
        .o_cond_valid  (condValid),
        .o_cond_true   (condTrue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conditions come in complementary pairs: even code is the base test, odd inverts it.
    function automatic logic condModel(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    task automatic compareBits(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput;
        compareBits("flags", flags, mFlags);
        compareBits("shadow_flags", shadowFlags, mShadow);
        compareBits("cond_valid", {3'b000, condValid}, {3'b000, mValid});
        compareBits("cond_true", {3'b000, condTrue}, {3'b000, mTrue});
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then compares.
    task automatic applyStimulus(input logic r, input logic [3:0] alu, input logic [3:0] wr,
                                 input logic sv, input logic rs, input logic req,
                                 input logic [3:0] code);
        logic [3:0] oldFlags;
        logic [3:0] oldShadow;
        rst = r;
        {aluN, aluZ, aluC, aluV} = alu;
        {nWrite, zWrite, cWrite, vWrite} = wr;
        save = sv;
        restore = rs;
        condReq = req;
        condCode = code;
        @(posedge clk);
        oldFlags  = mFlags;
        oldShadow = mShadow;
        if (r) begin
            mFlags  = 4'b0000;
            mShadow = 4'b0000;
            mValid  = 1'b0;
            mTrue   = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr[i]) mFlags[i] = alu[i];
            end
            if (rs) mFlags = oldShadow;
            if (sv) mShadow = oldFlags;
            mValid = req;
            if (req) mTrue = condModel(oldFlags, code);
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        {aluN, aluZ, aluC, aluV} = 4'h0;
        {nWrite, zWrite, cWrite, vWrite} = 4'h0;
        save = 1'b0; restore = 1'b0; condReq = 1'b0; condCode = 4'h0;
        @(negedge clk);

        // Test 1: reset state, then AL condition
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 4'hE);
        compareBits("lit_reset_flags", flags, 4'b0000);
        compareBits("lit_reset_shadow", shadowFlags, 4'b0000);
        compareBits("lit_reset_valid", {3'b000, condValid}, 4'b0000);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hE);
        compareBits("lit_al_valid", {3'b000, condValid}, 4'b0001);
        compareBits("lit_al_true", {3'b000, condTrue}, 4'b0001);
        idle();
        compareBits("lit_valid_drops", {3'b000, condValid}, 4'b0000);
        compareBits("lit_true_holds", {3'b000, condTrue}, 4'b0001);

        // Test 2: per-flag write enables
        applyStimulus(1'b0, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 4'h0);
        compareBits("lit_z_only", flags, 4'b0100);
        applyStimulus(1'b0, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0, 4'h0);
        compareBits("lit_all_write", flags, 4'b1010);

        // Test 3: no bypass of a same-cycle carry write
        applyStimulus(1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1, 4'h2);
        compareBits("lit_cs_old_c", {3'b000, condTrue}, 4'b0001);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2);
        compareBits("lit_cs_new_c", {3'b000, condTrue}, 4'b0000);

        // Test 4: every code against every flag value, back-to-back requests
        for (int f = 0; f < 16; f++) begin
            applyStimulus(1'b0, f[3:0], 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, c[3:0]);
            end
        end
        idle();

        // Spot checks pinning the model: flags 1001 (N=1,V=1) -> GE true, LT false, GT true
        applyStimulus(1'b0, 4'b1001, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA);
        compareBits("lit_ge_1001", {3'b000, condTrue}, 4'b0001);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hB);
        compareBits("lit_lt_1001", {3'b000, condTrue}, 4'b0000);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hC);
        compareBits("lit_gt_1001", {3'b000, condTrue}, 4'b0001);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF);
        compareBits("lit_nv_1001", {3'b000, condTrue}, 4'b0000);

        // Test 5: save, then save+restore swap
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        compareBits("lit_save_shadow", shadowFlags, 4'b1001);
        applyStimulus(1'b0, 4'b0110, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
        compareBits("lit_write_0110", flags, 4'b0110);
        applyStimulus(1'b0, 4'b1111, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0);
        compareBits("lit_swap_flags", flags, 4'b1001);
        compareBits("lit_swap_shadow", shadowFlags, 4'b0110);

        // Test 6: restore beats writes; reset drops a pending request
        applyStimulus(1'b0, 4'b0011, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 4'b1100, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0);
        compareBits("lit_shadow_0011", shadowFlags, 4'b0011);
        applyStimulus(1'b0, 4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0);
        compareBits("lit_restore_wins", flags, 4'b0011);
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hE);
        compareBits("lit_rst_valid", {3'b000, condValid}, 4'b0000);
        compareBits("lit_rst_flags", flags, 4'b0000);
        idle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
